// File: rtl/rbm_vote_argmax.sv
// Argmax back-end for the RBM vote vector: snapshots the votes on a finish edge,
// scans one class per cycle, hands the winner out over valid/ready and keeps accuracy stats.
module rbm_vote_argmax #(
  parameter int bitlength  = 12,
  parameter int output_dim = 10,
  parameter int cls_width  = 4,
  parameter int stat_width = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             finish,
  input  logic [output_dim*bitlength-1:0]  OutputData,
  input  logic [cls_width-1:0]             label,
  input  logic                             clear_stats,
  input  logic                             result_ready,
  output logic                             result_valid,
  output logic [cls_width-1:0]             class_id,
  output logic [bitlength-1:0]             max_count,
  output logic                             tie,
  output logic [stat_width-1:0]            correct_count,
  output logic [stat_width-1:0]            total_count,
  output logic                             busy,
  output logic                             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [cls_width-1:0]  LAST_IDX = cls_width'(output_dim - 1);
  localparam logic [stat_width-1:0] STAT_MAX = {stat_width{1'b1}};

  state_e                 state_q, state_d;
  logic                   finish_dly_q, finish_dly_d;
  logic [bitlength-1:0]   votes_q [output_dim];
  logic [bitlength-1:0]   votes_d [output_dim];
  logic [cls_width-1:0]   label_q, label_d;
  logic [cls_width-1:0]   idx_q, idx_d;
  logic [cls_width-1:0]   best_q, best_d;
  logic [bitlength-1:0]   max_q, max_d;
  logic                   tie_q, tie_d;
  logic                   valid_q, valid_d;
  logic [stat_width-1:0]  correct_q, correct_d;
  logic [stat_width-1:0]  total_q, total_d;
  logic                   overrun_q, overrun_d;

  logic                   edge_s;
  logic                   hit_s;
  logic [bitlength-1:0]   cur_vote_s;

  // Next-state, scan datapath and statistics update
  always_comb begin
    state_d      = state_q;
    finish_dly_d = finish;
    votes_d      = votes_q;
    label_d      = label_q;
    idx_d        = idx_q;
    best_d       = best_q;
    max_d        = max_q;
    tie_d        = tie_q;
    valid_d      = valid_q;
    correct_d    = correct_q;
    total_d      = total_q;
    overrun_d    = overrun_q;

    edge_s     = finish & ~finish_dly_q;
    cur_vote_s = votes_q[idx_q];
    // An out-of-range label can never match, whatever best_q holds.
    hit_s      = (32'(label_q) < 32'(output_dim)) && (best_q == label_q);

    case (state_q)
      IDLE: begin
        if (edge_s) begin
          for (int i = 0; i < output_dim; i++) begin
            votes_d[i] = OutputData[i*bitlength +: bitlength];
          end
          label_d = label;
          best_d  = {cls_width{1'b0}};
          max_d   = OutputData[bitlength-1:0];
          tie_d   = 1'b0;
          idx_d   = cls_width'(1);
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (cur_vote_s > max_q) begin
          best_d = idx_q;
          max_d  = cur_vote_s;
          tie_d  = 1'b0;
        end else if (cur_vote_s == max_q) begin
          tie_d = 1'b1;
        end else begin
          tie_d = tie_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (total_q != STAT_MAX) begin
            total_d = total_q + 1'b1;
          end else begin
            total_d = total_q;
          end
          if (hit_s && (correct_q != STAT_MAX)) begin
            correct_d = correct_q + 1'b1;
          end else begin
            correct_d = correct_q;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (edge_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end

    // A clear coinciding with a handshake wins over the increment.
    if (clear_stats) begin
      correct_d = {stat_width{1'b0}};
      total_d   = {stat_width{1'b0}};
      overrun_d = 1'b0;
    end else begin
      correct_d = correct_d;
    end
  end

  // State, snapshot and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      finish_dly_q <= 1'b0;
      for (int i = 0; i < output_dim; i++) begin
        votes_q[i] <= {bitlength{1'b0}};
      end
      label_q      <= {cls_width{1'b0}};
      idx_q        <= {cls_width{1'b0}};
      best_q       <= {cls_width{1'b0}};
      max_q        <= {bitlength{1'b0}};
      tie_q        <= 1'b0;
      valid_q      <= 1'b0;
      correct_q    <= {stat_width{1'b0}};
      total_q      <= {stat_width{1'b0}};
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      finish_dly_q <= finish_dly_d;
      votes_q      <= votes_d;
      label_q      <= label_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      max_q        <= max_d;
      tie_q        <= tie_d;
      valid_q      <= valid_d;
      correct_q    <= correct_d;
      total_q      <= total_d;
      overrun_q    <= overrun_d;
    end
  end

  assign result_valid  = valid_q;
  assign class_id      = best_q;
  assign max_count     = max_q;
  assign tie           = tie_q;
  assign correct_count = correct_q;
  assign total_count   = total_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rbm_vote_argmax.sv
// Directed bench for rbm_vote_argmax: vector table plus backpressure, overrun,
// saturation (via a narrow-counter second instance), clear and mid-scan reset sequences.
module tb_rbm_vote_argmax;

  logic         clock;
  logic         reset;
  logic         finish;
  logic [119:0] OutputData;
  logic [3:0]   label;
  logic         clear_stats;
  logic         result_ready;

  logic         result_valid;
  logic [3:0]   class_id;
  logic [11:0]  max_count;
  logic         tie;
  logic [15:0]  correct_count;
  logic [15:0]  total_count;
  logic         busy;
  logic         overrun;

  logic         s_valid;
  logic [3:0]   s_class;
  logic [11:0]  s_max;
  logic         s_tie;
  logic [2:0]   s_correct;
  logic [2:0]   s_total;
  logic         s_busy;
  logic         s_overrun;

  rbm_vote_argmax dut (
    .clock(clock), .reset(reset), .finish(finish), .OutputData(OutputData),
    .label(label), .clear_stats(clear_stats), .result_ready(result_ready),
    .result_valid(result_valid), .class_id(class_id), .max_count(max_count),
    .tie(tie), .correct_count(correct_count), .total_count(total_count),
    .busy(busy), .overrun(overrun)
  );

  // Same stimulus, 3-bit counters so saturation is reachable in a few results.
  rbm_vote_argmax #(.stat_width(3)) dut_sat (
    .clock(clock), .reset(reset), .finish(finish), .OutputData(OutputData),
    .label(label), .clear_stats(clear_stats), .result_ready(result_ready),
    .result_valid(s_valid), .class_id(s_class), .max_count(s_max),
    .tie(s_tie), .correct_count(s_correct), .total_count(s_total),
    .busy(s_busy), .overrun(s_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [119:0] votes;
    logic [3:0]   lbl;
    int           cls;
    int           mx;
    int           tie;
    int           hit;
  } vec_t;

  vec_t tbl [6];
  int   nvec;
  int   nerr;
  int   exp_correct;
  int   exp_total;

  function automatic logic [119:0] pk(input int v [10]);
    logic [119:0] r;
    r = 120'd0;
    for (int i = 0; i < 10; i++) r[i*12 +: 12] = v[i][11:0];
    return r;
  endfunction

  function automatic int sat7(input int x);
    return (x > 7) ? 7 : x;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_stats();
    chk("correct_count", correct_count, exp_correct);
    chk("total_count", total_count, exp_total);
    chk("sat_correct_count", s_correct, sat7(exp_correct));
    chk("sat_total_count", s_total, sat7(exp_total));
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (result_valid) break;
    end
  endtask

  task automatic run_vec(input int k);
    int e;
    @(negedge clock);
    OutputData   = tbl[k].votes;
    label        = tbl[k].lbl;
    result_ready = 1'b1;
    finish       = 1'b1;
    wait_valid(e);
    chk("latency", e, 10);
    chk("class_id", class_id, tbl[k].cls);
    chk("max_count", max_count, tbl[k].mx);
    chk("tie", tie, tbl[k].tie);
    @(posedge clock);
    #1;
    exp_total++;
    exp_correct += tbl[k].hit;
    chk("valid_after_hs", result_valid, 0);
    chk("busy_after_hs", busy, 0);
    chk_stats();
    @(negedge clock);
    finish = 1'b0;
  endtask

  initial begin
    int a [10];
    int e;
    nvec = 0; nerr = 0; exp_correct = 0; exp_total = 0;

    a = '{3, 1, 7, 0, 2, 5, 0, 0, 1, 4};
    tbl[0] = '{pk(a), 4'd2, 2, 7, 0, 1};
    a = '{1, 2, 3, 4, 9, 5, 6, 9, 8, 0};
    tbl[1] = '{pk(a), 4'd7, 4, 9, 1, 0};
    a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{pk(a), 4'd0, 0, 0, 1, 1};
    a = '{5, 5, 2, 0, 0, 0, 0, 0, 0, 4095};
    tbl[3] = '{pk(a), 4'd9, 9, 4095, 0, 1};
    a = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{pk(a), 4'd12, 3, 1, 0, 0};
    a = '{2048, 3, 2048, 7, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{pk(a), 4'd0, 0, 2048, 1, 1};

    reset = 1'b0; finish = 1'b0; OutputData = 120'd0; label = 4'd0;
    clear_stats = 1'b0; result_ready = 1'b0;
    #3;
    chk("rst_valid", result_valid, 0);
    chk("rst_class", class_id, 0);
    chk("rst_max", max_count, 0);
    chk("rst_tie", tie, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk_stats();
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(k);

    // Backpressure with an overrun edge and changed inputs while DONE
    @(negedge clock);
    OutputData = tbl[0].votes; label = tbl[0].lbl; result_ready = 1'b0; finish = 1'b1;
    wait_valid(e);
    chk("bp_latency", e, 10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 5) finish = 1'b0;
      if (i == 8) begin
        finish = 1'b1;
        OutputData = {120{1'b1}};
        label = 4'd0;
      end
      @(posedge clock);
      #1;
      chk("bp_valid", result_valid, 1);
      chk("bp_class", class_id, 2);
      chk("bp_max", max_count, 7);
      chk("bp_tie", tie, 0);
    end
    chk("bp_overrun", overrun, 1);
    chk("bp_busy", busy, 1);
    chk_stats();
    @(negedge clock);
    result_ready = 1'b1;
    @(posedge clock);
    #1;
    exp_total++;
    exp_correct++;
    chk("bp_valid_after_hs", result_valid, 0);
    chk_stats();
    repeat (5) @(posedge clock);
    #1;
    chk("no_recapture_busy", busy, 0);
    chk("no_recapture_valid", result_valid, 0);
    chk_stats();
    @(negedge clock);
    finish = 1'b0;

    // Three more results push the narrow counters into saturation
    run_vec(0);
    run_vec(1);
    run_vec(2);
    chk("overrun_sticky", overrun, 1);
    chk("sat_total_pinned", s_total, 7);

    // Clear coincident with a handshake
    @(negedge clock);
    OutputData = tbl[3].votes; label = tbl[3].lbl; result_ready = 1'b1; finish = 1'b1;
    wait_valid(e);
    chk("clr_latency", e, 10);
    clear_stats = 1'b1;
    @(posedge clock);
    #1;
    clear_stats = 1'b0;
    exp_total = 0;
    exp_correct = 0;
    chk("clr_valid", result_valid, 0);
    chk("clr_overrun", overrun, 0);
    chk_stats();
    @(negedge clock);
    finish = 1'b0;

    run_vec(4);

    // Reset mid-scan, finish held high through release
    @(negedge clock);
    OutputData = tbl[0].votes; label = tbl[0].lbl; result_ready = 1'b1; finish = 1'b1;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    chk("pre_rst_busy", busy, 1);
    #1;
    reset = 1'b0;
    #1;
    exp_total = 0;
    exp_correct = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_class", class_id, 0);
    chk("mid_rst_max", max_count, 0);
    chk("mid_rst_tie", tie, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk_stats();
    @(negedge clock);
    reset = 1'b1;
    wait_valid(e);
    chk("rel_latency", e, 10);
    chk("rel_class", class_id, 2);
    chk("rel_max", max_count, 7);
    chk("rel_tie", tie, 0);
    @(posedge clock);
    #1;
    exp_total++;
    exp_correct++;
    chk("rel_valid_after_hs", result_valid, 0);
    chk_stats();
    @(negedge clock);
    finish = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rbm_vote_argmax.md
# rbm_vote_argmax

Classification back-end placed directly downstream of the two-layer RBM top level. Once the iteration vote counts are final (`finish` rises), it takes one snapshot of the per-class vote vector and scans it sequentially to find the winning class. It presents the result over a valid/ready handshake and keeps running accuracy statistics against a supplied ground-truth label.

## Interface
- `bitlength`, 12, width of each per-class vote count
- `output_dim`, 10, number of classes (≥2)
- `cls_width`, 4, width of class index (≥ ceil(log2(output_dim)))
- `stat_width`, 16, width of statistics counters
- `clock` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-low; all state cleared while low
- `finish` in 1 — level from the upstream RBM top; stays high until that block is reset
- `OutputData` in output_dim*bitlength — packed vote counts, class i at bits [i*bitlength +: bitlength]
- `label` in cls_width — ground-truth class, sampled with the vote snapshot
- `clear_stats` in 1 — synchronous clear of `correct_count`, `total_count`, `overrun`
- `result_ready` in 1 — consumer accepts the result
- `result_valid` out 1 — result fields are valid
- `class_id` out cls_width — winning class
- `max_count` out bitlength — vote count of the winner
- `tie` out 1 — at least one other class equals `max_count`
- `correct_count` out stat_width — accepted results where `class_id == label`
- `total_count` out stat_width — accepted results
- `busy` out 1 — high in SCAN or DONE
- `overrun` out 1 — sticky: a `finish` rising edge arrived while busy

## Operation
- States: IDLE, SCAN, DONE. All outputs reset to 0; the state resets to IDLE.
- A registered `finish_d` detects the rising edge as `finish & ~finish_d`. `finish_d` is reset to 0, so `finish` already high when reset is released counts as an edge.
- **IDLE + edge:**
  - Capture all of `OutputData` into an internal vote array and capture `label`.
  - Initialise `best=0`, `max=votes[0]`, `tie=0`, `idx=1`.
  - Go to SCAN.
- **SCAN:** process one class per cycle, at `idx`.
  - If `votes[idx] > max`: set `best=idx`, `max=votes[idx]`, `tie=0`.
  - Else if `votes[idx] == max`: set `tie=1`.
  - Comparisons are unsigned. On ties the lowest index wins.
  - When `idx == output_dim-1`, go to DONE and set `result_valid=1`. Otherwise increment `idx`.
- **DONE:**
  - `class_id`, `max_count` and `tie` are held stable while `result_valid` is high.
  - On `result_valid & result_ready`:
    - Increment `total_count`.
    - Increment `correct_count` if `best == captured label`.
    - Deassert `result_valid` and go to IDLE.
  - Result fields keep their last values after acceptance.
- **Edge while in SCAN or DONE:** the edge is dropped and `overrun` is set. The snapshot is never modified.
- **Counters:** both saturate at 2^stat_width-1; they do not wrap.
- **`clear_stats`:**
  - Zeroes both counters and `overrun` at the next edge.
  - If it coincides with a handshake, the clear wins and the counters read 0.
  - It does not affect the FSM.
- **Out-of-range label** (≥ `output_dim`): the result is never counted as correct, but is still counted in `total_count`.

## Timing
- Capture edge E. SCAN occupies edges E+1 … E+output_dim-1. `result_valid` is high after edge E+output_dim-1 (9 cycles for 10 classes).
- `result_valid` may stay high indefinitely under backpressure.
- Handshake at edge H: `result_valid` is low and counters are updated after H. A new edge can be captured at H+1 at the earliest.
- `busy` is high from after E until after H.
- **Reset low mid-SCAN or in DONE:** immediately returns to IDLE and clears all outputs. After release, a new rising edge (or `finish` already high) is required before the next capture.

## Test plan
- Votes {3,1,7,0,2,5,0,0,1,4}, label=2, `result_ready`=1 → `class_id`=2, `max_count`=7, `tie`=0, `result_valid` 9 cycles after capture, `correct_count`=1, `total_count`=1.
- Votes with class 4=9 and class 7=9, others lower, label=7 → `class_id`=4, `tie`=1, `correct_count` unchanged, `total_count`+1.
- All votes 0 → `class_id`=0, `max_count`=0, `tie`=1.
- Hold `result_ready`=0 for 20 cycles → `result_valid` and fields stable. Toggle `finish` low/high during the wait → `overrun`=1, snapshot unchanged. Then ready=1 → one handshake, counts +1 only.
- Assert `reset` low at SCAN idx=5 → all outputs 0, state IDLE. With `finish` still high at release → a fresh capture occurs and the correct result follows.
- Preload `total_count` to 0xFFFE via 0xFFFE accepted results (or a force), then 3 more results → saturates at 0xFFFF. `clear_stats` coincident with a handshake → counters read 0.
